countdown_timer: RTL and testbench

Loadable down-counter: the counting-down counterpart of the configurable up-counter. It accepts a reload value over a valid/ready load port and counts down from it. When the count expires at zero it raises a one-cycle `underflow` pulse. It runs in one-shot or auto-reload mode and is the period/timeout source for blocks that need a programmable interval rather than a free-running wrap.

---
 rtl/countdown_timer_if.sv | 23 ++
 rtl/countdown_timer.sv | 108 ++++++++++
 tb/tb_countdown_timer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Load port for countdown_timer: valid/ready handshake carrying a reload value.
//   load_valid  master -> slave  load request
//   load_value  master -> slave  reload value, sampled on handshake
//   load_ready  slave -> master  load accepted when high
interface countdown_timer_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               load_valid;
  logic               load_ready;
  logic [COUNT_W-1:0] load_value;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and an expiry pulse.
//   clk, rst     clock, asynchronous active-high reset
//   load         slave side of the reload handshake (ready = not running)
//   start, stop  start/resume and pause requests, level sampled each edge
//   auto_reload  1: reload and keep running on expiry, 0: one-shot
//   count        current count
//   underflow    one-cycle pulse on the edge that handles count == 0 in RUN
//   busy         high while running
module countdown_timer #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   load,
  input  logic               start,
  input  logic               stop,
  input  logic               auto_reload,
  output logic [COUNT_W-1:0] count,
  output logic               underflow,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [COUNT_W-1:0] reload_q, reload_next;
  logic [COUNT_W-1:0] count_next;
  logic               underflow_next;
  logic               load_fire;

  // load_ready is low exactly while running, so a handshake only lands in IDLE/DONE
  assign load_fire = load.load_valid && load.load_ready;

  // State and output registers; busy/load_ready are registered copies of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      reload_q        <= '0;
      underflow       <= 1'b0;
      busy            <= 1'b0;
      load.load_ready <= 1'b1;
    end else begin
      state           <= state_next;
      count           <= count_next;
      reload_q        <= reload_next;
      underflow       <= underflow_next;
      busy            <= (state_next == RUN);
      load.load_ready <= (state_next != RUN);
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    state_next     = state;
    count_next     = count;
    reload_next    = reload_q;
    underflow_next = 1'b0;

    case (state)
      IDLE: begin
        if (load_fire) begin
          reload_next = load.load_value;
          count_next  = load.load_value;
        end else if (start && !stop) begin
          // resume from whatever count was left behind
          state_next = RUN;
        end
      end

      DONE: begin
        if (load_fire) begin
          reload_next = load.load_value;
          count_next  = load.load_value;
          state_next  = IDLE;
        end else if (start) begin
          count_next = reload_q;
          state_next = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (count == '0) begin
          underflow_next = 1'b1;
          if (auto_reload) begin
            count_next = reload_q;
          end else begin
            state_next = DONE;
          end
        end else begin
          // zero is handled above, so this never wraps
          count_next = count - COUNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle against
// a behavioural model.
module tb_countdown_timer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         underflow;
  logic         busy;

  countdown_timer_if #(.COUNT_W(W)) lif ();

  countdown_timer #(.COUNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (lif),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .underflow   (underflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a running flag, an "expired" flag, the count and the reload value
  int m_count, m_reload;
  bit m_run, m_expired, m_uf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_reload = 0; m_run = 0; m_expired = 0; m_uf = 0;
    end else begin
      m_uf = 0;
      if (m_run) begin
        if (stop) begin
          m_run = 0;
        end else if (m_count == 0) begin
          m_uf = 1;
          if (auto_reload) m_count = m_reload;
          else begin m_run = 0; m_expired = 1; end
        end else begin
          m_count = m_count - 1;
        end
      end else if (lif.load_valid) begin
        m_reload = int'(lif.load_value);
        m_count = m_reload;
        m_expired = 0;
      end else if (m_expired && start) begin
        m_run = 1; m_expired = 0; m_count = m_reload;
      end else if (!m_expired && start && !stop) begin
        m_run = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_count",      int'(count),          m_count);
      chk("cyc_underflow",  int'(underflow),      int'(m_uf));
      chk("cyc_busy",       int'(busy),           int'(m_run));
      chk("cyc_load_ready", int'(lif.load_ready), int'(!m_run));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    lif.load_valid = 1'b1;
    lif.load_value = W'(v);
    tick();
    lif.load_valid = 1'b0;
  endtask

  task automatic do_start(input bit ar);
    auto_reload = ar;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_uf"},    int'(underflow), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_ready"}, int'(lif.load_ready), 1);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; start = 0; stop = 0; auto_reload = 0;
    lif.load_valid = 0; lif.load_value = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk_reset_outputs("rst");
    repeat (5) tick();
    chk_reset_outputs("rst_idle");

    // One-shot from 5
    do_load(5);
    chk("os_load_count", int'(count), 5);
    do_start(1'b0);
    chk("os_e0_count", int'(count), 5);
    chk("os_e0_busy", int'(busy), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("os_run_count", int'(count), 5 - k);
      chk("os_run_uf", int'(underflow), 0);
    end
    tick();
    chk("os_uf", int'(underflow), 1);
    chk("os_done_busy", int'(busy), 0);
    chk("os_done_ready", int'(lif.load_ready), 1);
    tick();
    chk("os_uf_drop", int'(underflow), 0);
    chk("os_hold0", int'(count), 0);

    // Auto-reload from 3: period 4
    do_load(3);
    do_start(1'b1);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (underflow) begin
        pulses++;
        chk("ar_phase", i % 4, 0);
        chk("ar_reload", int'(count), 3);
      end
    end
    chk("ar_pulses", pulses, 5);
    stop = 1'b1; tick(); stop = 1'b0; auto_reload = 1'b0;
    chk("ar_stop_busy", int'(busy), 0);

    // Pause at 6, hold, resume
    do_load(10);
    do_start(1'b0);
    repeat (4) tick();
    chk("ps_at6", int'(count), 6);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("ps_busy", int'(busy), 0);
    chk("ps_stop_count", int'(count), 6);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ps_hold", int'(count), 6);
    end
    do_start(1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rs_no_uf", int'(underflow), 0);
    end
    tick();
    chk("rs_uf", int'(underflow), 1);

    // start together with stop in IDLE
    do_load(4);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    chk("ss_count", int'(count), 4);

    // Load attempt while running is ignored
    do_start(1'b0);
    lif.load_valid = 1'b1; lif.load_value = W'(9);
    chk("lr_ready", int'(lif.load_ready), 0);
    tick();
    chk("lr_count", int'(count), 3);
    tick();
    lif.load_valid = 1'b0;
    repeat (3) tick();
    chk("lr_uf", int'(underflow), 1);
    do_start(1'b0);
    chk("lr_reload_kept", int'(count), 4);
    stop = 1'b1; tick(); stop = 1'b0;

    // Reload of zero: expiry on first edge after start
    do_load(0);
    do_start(1'b0);
    chk("z_busy", int'(busy), 1);
    chk("z_count", int'(count), 0);
    tick();
    chk("z_uf", int'(underflow), 1);
    chk("z_done", int'(busy), 0);

    // Full-scale reload: 16 edges to expiry, no wrap
    do_load(15);
    do_start(1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("fs_no_uf", int'(underflow), 0);
    end
    chk("fs_zero", int'(count), 0);
    tick();
    chk("fs_uf", int'(underflow), 1);
    chk("fs_count", int'(count), 0);

    // Asynchronous reset mid-run at count 2
    do_load(5);
    do_start(1'b0);
    repeat (3) tick();
    chk("mr_at2", int'(count), 2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mr");
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk_reset_outputs("mr_idle");

    // Randomized phase, checked by the every-cycle comparison
    for (int n = 0; n < 800; n++) begin
      start          = ($urandom % 4) == 0;
      stop           = ($urandom % 10) == 0;
      auto_reload    = $urandom % 2;
      lif.load_valid = ($urandom % 4) == 0;
      lif.load_value = (($urandom % 4) == 0) ? W'($urandom_range(0, 15))
                                             : W'($urandom_range(0, 5));
      if (($urandom % 150) == 0) begin
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rnd_rst");
        tick();
        rst = 1'b0;
      end
      tick();
    end

    start = 0; stop = 0; lif.load_valid = 0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
